keypad_encoder: RTL and testbench

Multi-tap keypad encoder: the inverse of the keypad decoder FSM. Accepts one command (an ASCII letter, or submit-word / clear / game-end) and replays it as timed keypad activity on `cur_key`/`strobe`: N presses of the letter's key, then the submit-letter key. It sits between the autoplay/self-test logic and the keypad decoder input mux, so the decoder can be driven without a physical keypad.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_letter_map.sv | 67 ++++++
 rtl/keypad_encoder.sv | 202 ++++++++++++++++++++
 tb/tb_keypad_encoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: definitions shared by the keypad encoder and its letter map.
//   - key codes: row one-hot in [7:4], column one-hot in [3:0] (row0/col0 = MSB)
//   - encoder_state_t: encoder FSM states
//   - encoder_cmd_t:   command encodings accepted on the cmd input
package keypad_pkg;

    // Letter group keys
    localparam logic [7:0] KEY_ABC  = 8'h84;
    localparam logic [7:0] KEY_DEF  = 8'h82;
    localparam logic [7:0] KEY_GHI  = 8'h48;
    localparam logic [7:0] KEY_JKL  = 8'h44;
    localparam logic [7:0] KEY_MNO  = 8'h42;
    localparam logic [7:0] KEY_PQRS = 8'h28;
    localparam logic [7:0] KEY_TUV  = 8'h24;
    localparam logic [7:0] KEY_WXYZ = 8'h22;

    // Control keys
    localparam logic [7:0] KEY_SUBMIT_LETTER = 8'h18;
    localparam logic [7:0] KEY_CLEAR         = 8'h14;
    localparam logic [7:0] KEY_SUBMIT_WORD   = 8'h12;
    localparam logic [7:0] KEY_GAME_END      = 8'h21;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOLD     = 3'd1,
        ST_GAP      = 3'd2,
        ST_SUB_HOLD = 3'd3,
        ST_SUB_GAP  = 3'd4
    } encoder_state_t;

    typedef enum logic [1:0] {
        CMD_LETTER      = 2'b00,
        CMD_SUBMIT_WORD = 2'b01,
        CMD_CLEAR       = 2'b10,
        CMD_GAME_END    = 2'b11
    } encoder_cmd_t;

endpackage

// File: rtl/keypad_letter_map.sv
// keypad_letter_map: combinational ASCII -> multi-tap key translation.
//   ascii    in  8  letter, upper or lower case
//   valid    out 1  ascii is 'A'-'Z' or 'a'-'z'
//   key_code out 8  group key for the letter (0 when invalid)
//   presses  out 3  taps needed to reach the letter within its group, 1..4
//                   (0 when invalid)
module keypad_letter_map
    import keypad_pkg::*;
(
    input  logic [7:0] ascii,
    output logic       valid,
    output logic [7:0] key_code,
    output logic [2:0] presses
);

    logic [7:0] upper;
    logic [7:0] idx;
    logic [7:0] base;
    logic [2:0] offset;

    always_comb begin
        upper = ascii;
        if (ascii >= 8'd97 && ascii <= 8'd122) begin
            upper = ascii - 8'd32;
        end

        valid = (upper >= 8'd65) && (upper <= 8'd90);
        idx   = upper - 8'd65;

        // Groups are 3 letters wide except PQRS and WXYZ (4 letters).
        key_code = 8'h00;
        base     = 8'd0;
        if (!valid) begin
            key_code = 8'h00;
            base     = 8'd0;
        end else if (idx < 8'd3) begin
            key_code = KEY_ABC;
            base     = 8'd0;
        end else if (idx < 8'd6) begin
            key_code = KEY_DEF;
            base     = 8'd3;
        end else if (idx < 8'd9) begin
            key_code = KEY_GHI;
            base     = 8'd6;
        end else if (idx < 8'd12) begin
            key_code = KEY_JKL;
            base     = 8'd9;
        end else if (idx < 8'd15) begin
            key_code = KEY_MNO;
            base     = 8'd12;
        end else if (idx < 8'd19) begin
            key_code = KEY_PQRS;
            base     = 8'd15;
        end else if (idx < 8'd22) begin
            key_code = KEY_TUV;
            base     = 8'd19;
        end else begin
            key_code = KEY_WXYZ;
            base     = 8'd22;
        end

        // Offset within a group is at most 3, so three bits hold it exactly.
        offset  = 3'(idx - base);
        presses = valid ? (offset + 3'd1) : 3'd0;
    end

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: replays one command as timed keypad activity.
//   clk, rst   clock; asynchronous active-high reset
//   start      command request, sampled only while idle
//   cmd        00 letter, 01 submit word, 10 clear, 11 game end
//   ascii      letter for cmd=00 (lower case folded to upper)
//   cur_key    key code being "held" (0 when no key pressed)
//   strobe     one-cycle pulse on the first cycle of each press
//   busy       high while a sequence is being played
//   done       one-cycle pulse in the last cycle of a sequence
//   error      one-cycle pulse after a letter command with invalid ascii
//   dbg_state  current FSM state (encoder_state_t encoding)
//
// Handshake: start is a request without a ready. It is taken only when the
// FSM is idle (busy low); a start seen while busy, including the done cycle,
// is dropped, not queued. The request is complete when done or error pulses.
// All outputs come straight from flops.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] ascii,
    output logic [7:0] cur_key,
    output logic       strobe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] dbg_state
);

    localparam int MAX_PHASE = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW        = $clog2(MAX_PHASE + 1);

    // Timer counts down to zero; the phase ends in the cycle it reads zero.
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

    encoder_state_t state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [2:0]     presses_q, presses_d;  // presses left, including current
    logic [7:0]     key_q, key_d;
    logic           letter_q, letter_d;    // latched "command is a letter"

    logic [7:0]     cur_key_d;
    logic           strobe_d, busy_d, done_d, error_d;

    logic           map_valid;
    logic [7:0]     map_key;
    logic [2:0]     map_presses;
    encoder_cmd_t   cmd_e;

    assign cmd_e = encoder_cmd_t'(cmd);

    keypad_letter_map u_letter_map (
        .ascii    (ascii),
        .valid    (map_valid),
        .key_code (map_key),
        .presses  (map_presses)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        presses_d = presses_q;
        key_d     = key_q;
        letter_d  = letter_q;
        error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cmd_e == CMD_LETTER) begin
                        if (map_valid) begin
                            key_d     = map_key;
                            presses_d = map_presses;
                            letter_d  = 1'b1;
                            timer_d   = HOLD_LOAD;
                            state_d   = ST_HOLD;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else begin
                        case (cmd_e)
                            CMD_SUBMIT_WORD: key_d = KEY_SUBMIT_WORD;
                            CMD_CLEAR:       key_d = KEY_CLEAR;
                            default:         key_d = KEY_GAME_END;
                        endcase
                        presses_d = 3'd1;
                        letter_d  = 1'b0;
                        timer_d   = HOLD_LOAD;
                        state_d   = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (timer_q == '0) begin
                    timer_d = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            ST_GAP: begin
                if (timer_q == '0) begin
                    if (presses_q > 3'd1) begin
                        presses_d = presses_q - 3'd1;
                        timer_d   = HOLD_LOAD;
                        state_d   = ST_HOLD;
                    end else if (letter_q) begin
                        timer_d = HOLD_LOAD;
                        state_d = ST_SUB_HOLD;
                    end else begin
                        timer_d = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            ST_SUB_HOLD: begin
                if (timer_q == '0) begin
                    timer_d = GAP_LOAD;
                    state_d = ST_SUB_GAP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            ST_SUB_GAP: begin
                if (timer_q == '0) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            default: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they can be registered
        // and still line up with the state they describe.
        strobe_d = ((state_d == ST_HOLD)     && (state_q != ST_HOLD)) ||
                   ((state_d == ST_SUB_HOLD) && (state_q != ST_SUB_HOLD));

        cur_key_d = 8'h00;
        if (state_d == ST_HOLD) begin
            cur_key_d = key_d;
        end else if (state_d == ST_SUB_HOLD) begin
            cur_key_d = KEY_SUBMIT_LETTER;
        end

        busy_d = (state_d != ST_IDLE);

        // Final gap: the submit-letter gap, or the single gap of a
        // non-letter command.
        done_d = (timer_d == '0) &&
                 ((state_d == ST_SUB_GAP) || ((state_d == ST_GAP) && !letter_d));
    end

    // State, counters and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            presses_q <= 3'd0;
            key_q     <= 8'h00;
            letter_q  <= 1'b0;
            cur_key   <= 8'h00;
            strobe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            presses_q <= presses_d;
            key_q     <= key_d;
            letter_q  <= letter_d;
            cur_key   <= cur_key_d;
            strobe    <= strobe_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_encoder.sv
module tb_keypad_encoder;

    localparam int H    = 2;
    localparam int G    = 4;
    localparam int MAXC = 8192;
    localparam int W    = 30;  // {kind[1:0], cycle[19:0], key[7:0]}

    localparam logic [1:0] EV_STROBE = 2'd1;
    localparam logic [1:0] EV_DONE   = 2'd2;
    localparam logic [1:0] EV_ERR    = 2'd3;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] ascii;
    logic [7:0] cur_key;
    logic       strobe;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] dbg_state;

    keypad_encoder #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cmd       (cmd),
        .ascii     (ascii),
        .cur_key   (cur_key),
        .strobe    (strobe),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model state ----------------
    int         total = 0;
    int         bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0] exp_key  [MAXC];
    logic       exp_busy [MAXC];
    int         free_at = 0;
    bit         mon_en  = 0;

    int         group_size [8] = '{3, 3, 3, 3, 3, 4, 3, 4};
    logic [7:0] group_code [8] = '{8'h84, 8'h82, 8'h48, 8'h44, 8'h42, 8'h28, 8'h24, 8'h22};
    logic [7:0] edge_ascii [8] = '{8'd64, 8'd91, 8'd96, 8'd123, 8'd65, 8'd90, 8'd97, 8'd122};

    function automatic logic [W-1:0] ev(input logic [1:0] kind, input int c, input logic [7:0] key);
        logic [19:0] c20;
        c20 = c[19:0];
        return {kind, c20, key};
    endfunction

    // Letter -> (group key, taps) by walking the alphabet groups.
    function automatic void letter_info(input logic [7:0] a, output bit ok,
                                        output logic [7:0] code, output int n);
        int u;
        int idx;
        u    = int'(a);
        ok   = 0;
        code = 8'h00;
        n    = 0;
        if (u >= 97 && u <= 122) u = u - 32;
        if (u < 65 || u > 90) return;
        ok  = 1;
        idx = u - 65;
        for (int g = 0; g < 8; g++) begin
            if (idx < group_size[g]) begin
                code = group_code[g];
                n    = idx + 1;
                return;
            end
            idx = idx - group_size[g];
        end
    endfunction

    // Schedule the full expected response for a command accepted at cycle c.
    task automatic model_accept(input int c, input logic [1:0] cm, input logic [7:0] a);
        logic [7:0] keys[$];
        bit         ok;
        logic [7:0] code;
        int         n;
        int         period;
        int         base;
        keys.delete();
        if (cm == 2'b00) begin
            letter_info(a, ok, code, n);
            if (!ok) begin
                exp_q.push_back(ev(EV_ERR, c + 1, 8'h00));
                free_at = c + 1;
                return;
            end
            for (int i = 0; i < n; i++) keys.push_back(code);
            keys.push_back(8'h18);
        end else if (cm == 2'b01) begin
            keys.push_back(8'h12);
        end else if (cm == 2'b10) begin
            keys.push_back(8'h14);
        end else begin
            keys.push_back(8'h21);
        end
        period = H + G;
        for (int p = 0; p < keys.size(); p++) begin
            base = c + 1 + p * period;
            exp_q.push_back(ev(EV_STROBE, base, keys[p]));
            for (int k = 0; k < period; k++) begin
                if (base + k < MAXC) begin
                    exp_busy[base + k] = 1'b1;
                    exp_key[base + k]  = (k < H) ? keys[p] : 8'h00;
                end
            end
        end
        exp_q.push_back(ev(EV_DONE, c + keys.size() * period, 8'h00));
        free_at = c + keys.size() * period + 1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input logic s, input logic [1:0] c, input logic [7:0] a);
        @(posedge clk);
        #1;
        start = s;
        cmd   = c;
        ascii = a;
        if (s && !rst && cyc >= free_at) model_accept(cyc, c, a);
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] a);
        drive_cycle(1'b1, c, a);
        drive_cycle(1'b0, 2'b00, 8'h00);
    endtask

    task automatic wait_idle();
        while (cyc < free_at + 1) drive_cycle(1'b0, 2'b00, 8'h00);
    endtask

    // Asynchronous reset asserted mid-cycle; everything pending is dropped.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        for (int i = cyc; i < MAXC; i++) begin
            exp_key[i]  = 8'h00;
            exp_busy[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        free_at = cyc;
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check_event(input logic [1:0] kind, input string name);
        logic [W-1:0] got;
        logic [W-1:0] want;
        got   = ev(kind, cyc, cur_key & {8{kind == EV_STROBE}});
        total = total + 1;
        if (exp_q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL %s unexpected at cycle %0d: got %h, nothing expected", name, cyc, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                bad = bad + 1;
                $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, got, want);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && cyc < MAXC) begin
            // Expected events whose cycle has passed without the DUT showing them.
            while (exp_q.size() > 0 && int'(exp_q[0][27:8]) < cyc) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL missing_event at cycle %0d: got none required %h", cyc, exp_q[0]);
                void'(exp_q.pop_front());
            end
            total = total + 1;
            if (cur_key !== exp_key[cyc]) begin
                bad = bad + 1;
                $display("FAIL cur_key at cycle %0d: got %h required %h", cyc, cur_key, exp_key[cyc]);
            end
            total = total + 1;
            if (busy !== exp_busy[cyc]) begin
                bad = bad + 1;
                $display("FAIL busy at cycle %0d: got %b required %b", cyc, busy, exp_busy[cyc]);
            end
            if (error  === 1'b1) check_event(EV_ERR,    "error");
            if (strobe === 1'b1) check_event(EV_STROBE, "strobe");
            if (done   === 1'b1) check_event(EV_DONE,   "done");
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_outputs(input string tag);
        total = total + 1;
        if (cur_key !== 8'h00 || strobe !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || error !== 1'b0 || dbg_state !== 3'd0) begin
            bad = bad + 1;
            $display("FAIL %s: got key=%h strobe=%b busy=%b done=%b error=%b state=%0d required all zero",
                     tag, cur_key, strobe, busy, done, error, dbg_state);
        end
    endtask

    initial begin
        logic [1:0] rc;
        logic [7:0] ra;
        int         sel;

        for (int i = 0; i < MAXC; i++) begin
            exp_key[i]  = 8'h00;
            exp_busy[i] = 1'b0;
        end
        rst   = 1'b1;
        start = 1'b0;
        cmd   = 2'b00;
        ascii = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        free_at = cyc;
        mon_en  = 1;

        // Reset in the middle of the first HOLD of 'Q', then a normal command.
        drive_cycle(1'b1, 2'b00, 8'd81);
        drive_cycle(1'b0, 2'b00, 8'h00);
        do_reset();
        @(negedge clk);
        check_reset_outputs("reset_mid_hold");
        drive_cycle(1'b0, 2'b00, 8'h00);
        issue(2'b00, 8'd65);
        wait_idle();

        // Directed commands
        issue(2'b00, 8'd67);   // 'C'
        wait_idle();
        issue(2'b00, 8'd122);  // 'z'
        wait_idle();
        issue(2'b01, 8'h00);   // submit word
        wait_idle();
        issue(2'b10, 8'h00);   // clear
        wait_idle();
        issue(2'b11, 8'h00);   // game end
        wait_idle();
        issue(2'b00, 8'd64);   // '@' -> error
        wait_idle();
        issue(2'b00, 8'd83);   // 'S'
        wait_idle();

        // start held high with 'A' for 20 cycles: two back-to-back sequences.
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 2'b00, 8'd65);
        drive_cycle(1'b0, 2'b00, 8'h00);
        wait_idle();

        // Random commands; inputs change every cycle, start often while busy.
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       ra = 8'(65 + $urandom_range(0, 25));
                1:       ra = 8'(97 + $urandom_range(0, 25));
                2:       ra = 8'($urandom_range(0, 255));
                default: ra = edge_ascii[$urandom_range(0, 7)];
            endcase
            rc = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            drive_cycle(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0, rc, ra);
        end
        drive_cycle(1'b0, 2'b00, 8'h00);
        wait_idle();
        repeat (3) drive_cycle(1'b0, 2'b00, 8'h00);

        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: got %0d events still pending required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
